// File: rtl/gpio_irq_ctrl.sv
// -----------------------------------------------------------------------------
// gpio_irq_ctrl
//
// GPIO controller core that sits between the register file and the pad-level
// tri-state buffers. It provides:
//   - a per-pin input synchroniser followed by a per-pin debounce filter
//   - per-pin edge interrupts (rising / falling / both) with sticky W1C
//     status bits and one masked, registered aggregate interrupt line
//   - an output data register with atomic per-bit set / clear / toggle
//
// Parameters:
//   WIDTH           number of GPIO pins
//   SYNC_STAGES     synchroniser depth per input pin (2..4)
//   DEBOUNCE_CYCLES stable cycles needed to accept a new level (0 = bypass)
//   CNT_W           debounce counter width (DEBOUNCE_CYCLES < 2**CNT_W)
//
// Ports:
//   clk, rst            clock and synchronous active-high reset
//   pin_in              raw pad input (asynchronous to clk)
//   pin_out, pin_oe     pad output data and output enable (1 = drive)
//   dir_wr, dir_wdata   load the direction register
//   out_wr, out_wdata   load the output data register
//   out_set/clr/tgl     per-bit atomic strobes on the output register
//   irq_mode            two bits per pin: 00 off, 01 rise, 10 fall, 11 both
//   irq_en              per-pin mask for the irq line
//   irq_clr             per-bit write-one-to-clear for irq_status
//   data_in             debounced, synchronised pin state
//   irq_status          sticky edge flags
//   irq                 registered OR of (irq_status & irq_en)
// -----------------------------------------------------------------------------
module gpio_irq_ctrl #(
  parameter int WIDTH           = 8,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     pin_in,
  output logic [WIDTH-1:0]     pin_out,
  output logic [WIDTH-1:0]     pin_oe,
  input  logic                 dir_wr,
  input  logic [WIDTH-1:0]     dir_wdata,
  input  logic                 out_wr,
  input  logic [WIDTH-1:0]     out_wdata,
  input  logic [WIDTH-1:0]     out_set,
  input  logic [WIDTH-1:0]     out_clr,
  input  logic [WIDTH-1:0]     out_tgl,
  input  logic [2*WIDTH-1:0]   irq_mode,
  input  logic [WIDTH-1:0]     irq_en,
  input  logic [WIDTH-1:0]     irq_clr,
  output logic [WIDTH-1:0]     data_in,
  output logic [WIDTH-1:0]     irq_status,
  output logic                 irq
);

  // ---------------------------------------------------------------------------
  // Helper functions
  // ---------------------------------------------------------------------------

  // Per-pin edge qualification: bit 2i enables rising, bit 2i+1 enables falling.
  function automatic logic [WIDTH-1:0] edge_hits(
    input logic [WIDTH-1:0]   rise,
    input logic [WIDTH-1:0]   fall,
    input logic [2*WIDTH-1:0] mode
  );
    logic [WIDTH-1:0] hits;
    hits = '0;
    for (int i = 0; i < WIDTH; i++) begin
      hits[i] = (rise[i] & mode[2*i]) | (fall[i] & mode[2*i+1]);
    end
    return hits;
  endfunction

  // Output register next value. Priority per bit: write > clear > set > toggle,
  // so a bit with both clear and set ends up cleared.
  function automatic logic [WIDTH-1:0] out_next(
    input logic [WIDTH-1:0] cur,
    input logic             wr,
    input logic [WIDTH-1:0] wdata,
    input logic [WIDTH-1:0] set_m,
    input logic [WIDTH-1:0] clr_m,
    input logic [WIDTH-1:0] tgl_m
  );
    logic [WIDTH-1:0] nxt;
    nxt = cur;
    for (int i = 0; i < WIDTH; i++) begin
      if (wr) begin
        nxt[i] = wdata[i];
      end else if (clr_m[i]) begin
        nxt[i] = 1'b0;
      end else if (set_m[i]) begin
        nxt[i] = 1'b1;
      end else if (tgl_m[i]) begin
        nxt[i] = ~cur[i];
      end else begin
        nxt[i] = cur[i];
      end
    end
    return nxt;
  endfunction

  // ---------------------------------------------------------------------------
  // Input synchroniser
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
  logic [WIDTH-1:0]                  sync_s;

  // Shift raw pad levels through the synchroniser chain.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q[0] <= pin_in;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        sync_q[s] <= sync_q[s-1];
      end
    end
  end

  assign sync_s = sync_q[SYNC_STAGES-1];

  // ---------------------------------------------------------------------------
  // Debounce
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] data_in_q;
  logic [WIDTH-1:0] data_in_d;

  generate
    if (DEBOUNCE_CYCLES > 0) begin : g_debounce
      localparam logic [CNT_W-1:0] CntMax = CNT_W'(DEBOUNCE_CYCLES - 1);
      localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

      logic [WIDTH-1:0][CNT_W-1:0] cnt_q;
      logic [WIDTH-1:0][CNT_W-1:0] cnt_d;

      // Count consecutive cycles the synchronised level differs from the
      // accepted level; any return to the accepted level restarts the count.
      // The counter is cleared on acceptance, so it never passes CntMax.
      always_comb begin
        cnt_d     = cnt_q;
        data_in_d = data_in_q;
        for (int i = 0; i < WIDTH; i++) begin
          if (sync_s[i] == data_in_q[i]) begin
            cnt_d[i] = '0;
          end else if (cnt_q[i] == CntMax) begin
            data_in_d[i] = sync_s[i];
            cnt_d[i]     = '0;
          end else begin
            cnt_d[i] = cnt_q[i] + CntOne;
          end
        end
      end

      // Debounce counter state.
      always_ff @(posedge clk) begin
        if (rst) begin
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_d;
        end
      end
    end else begin : g_no_debounce
      // Debounce bypassed: accept the synchronised level every cycle.
      always_comb begin
        data_in_d = sync_s;
      end
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Edge detect, interrupt status, output and direction registers
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] rise_s;
  logic [WIDTH-1:0] fall_s;
  logic [WIDTH-1:0] hit_s;
  logic [WIDTH-1:0] irq_status_q;
  logic [WIDTH-1:0] irq_status_d;
  logic             irq_q;
  logic             irq_d;
  logic [WIDTH-1:0] out_q;
  logic [WIDTH-1:0] out_d;
  logic [WIDTH-1:0] dir_q;
  logic [WIDTH-1:0] dir_d;

  // Next-state logic for status, irq, output and direction registers.
  // Edges are taken from the accepted-level update so status is set on the
  // same edge data_in changes; a same-cycle clear loses against a new set.
  always_comb begin
    rise_s       = data_in_d & ~data_in_q;
    fall_s       = ~data_in_d & data_in_q;
    hit_s        = edge_hits(rise_s, fall_s, irq_mode);
    irq_status_d = (irq_status_q & ~irq_clr) | hit_s;
    irq_d        = |(irq_status_q & irq_en);
    out_d        = out_next(out_q, out_wr, out_wdata, out_set, out_clr, out_tgl);
    if (dir_wr) begin
      dir_d = dir_wdata;
    end else begin
      dir_d = dir_q;
    end
  end

  // Architectural state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_in_q    <= '0;
      irq_status_q <= '0;
      irq_q        <= 1'b0;
      out_q        <= '0;
      dir_q        <= '0;
    end else begin
      data_in_q    <= data_in_d;
      irq_status_q <= irq_status_d;
      irq_q        <= irq_d;
      out_q        <= out_d;
      dir_q        <= dir_d;
    end
  end

  assign pin_out    = out_q;
  assign pin_oe     = dir_q;
  assign data_in    = data_in_q;
  assign irq_status = irq_status_q;
  assign irq        = irq_q;

endmodule

// File: tb/tb_gpio_irq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_gpio_irq_ctrl
//
// Directed testbench for gpio_irq_ctrl with default parameters
// (WIDTH 8, SYNC_STAGES 2, DEBOUNCE_CYCLES 4). Inputs change on the falling
// edge and outputs are sampled on the falling edge. A new pin level applied
// before rising edge 0 reaches data_in at rising edge 5.
// -----------------------------------------------------------------------------
module tb_gpio_irq_ctrl;

  logic        clk;
  logic        rst;
  logic [7:0]  pin_in;
  logic [7:0]  pin_out;
  logic [7:0]  pin_oe;
  logic        dir_wr;
  logic [7:0]  dir_wdata;
  logic        out_wr;
  logic [7:0]  out_wdata;
  logic [7:0]  out_set;
  logic [7:0]  out_clr;
  logic [7:0]  out_tgl;
  logic [15:0] irq_mode;
  logic [7:0]  irq_en;
  logic [7:0]  irq_clr;
  logic [7:0]  data_in;
  logic [7:0]  irq_status;
  logic        irq;

  int n_total;
  int n_bad;

  gpio_irq_ctrl #(
    .WIDTH           (8),
    .SYNC_STAGES     (2),
    .DEBOUNCE_CYCLES (4),
    .CNT_W           (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .pin_in     (pin_in),
    .pin_out    (pin_out),
    .pin_oe     (pin_oe),
    .dir_wr     (dir_wr),
    .dir_wdata  (dir_wdata),
    .out_wr     (out_wr),
    .out_wdata  (out_wdata),
    .out_set    (out_set),
    .out_clr    (out_clr),
    .out_tgl    (out_tgl),
    .irq_mode   (irq_mode),
    .irq_en     (irq_en),
    .irq_clr    (irq_clr),
    .data_in    (data_in),
    .irq_status (irq_status),
    .irq        (irq)
  );

  // Free-running 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Count one comparison and report it if the observed value is wrong.
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_total++;
    if (obs !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // Advance n clock cycles, returning just after a falling edge.
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    n_total   = 0;
    n_bad     = 0;
    rst       = 1'b1;
    pin_in    = 8'h00;
    dir_wr    = 1'b0;
    dir_wdata = 8'h00;
    out_wr    = 1'b0;
    out_wdata = 8'h00;
    out_set   = 8'h00;
    out_clr   = 8'h00;
    out_tgl   = 8'h00;
    irq_mode  = 16'h0000;
    irq_en    = 8'h00;
    irq_clr   = 8'h00;

    // ---------------- reset state ----------------
    cyc(1);
    chk("rst_pin_out", {24'd0, pin_out}, 32'h0);
    chk("rst_pin_oe", {24'd0, pin_oe}, 32'h0);
    chk("rst_data_in", {24'd0, data_in}, 32'h0);
    chk("rst_status", {24'd0, irq_status}, 32'h0);
    chk("rst_irq", {31'd0, irq}, 32'h0);
    cyc(1);

    // ---------------- latency: A5 appears after edge 5 ----------------
    rst    = 1'b0;
    pin_in = 8'hA5;
    cyc(5);
    chk("lat_before", {24'd0, data_in}, 32'h0);
    cyc(1);
    chk("lat_at5", {24'd0, data_in}, 32'hA5);
    chk("lat_status", {24'd0, irq_status}, 32'h0);

    // ---------------- pin0 rising interrupt ----------------
    pin_in = 8'hA4;
    cyc(8);
    chk("p0_low", {24'd0, data_in}, 32'hA4);
    irq_mode = 16'h0001;
    irq_en   = 8'h01;
    pin_in   = 8'hA5;
    cyc(5);
    chk("p0_status_pre", {24'd0, irq_status}, 32'h0);
    cyc(1);
    chk("p0_status", {24'd0, irq_status}, 32'h01);
    chk("p0_irq_lag", {31'd0, irq}, 32'h0);
    cyc(1);
    chk("p0_irq", {31'd0, irq}, 32'h1);
    irq_clr = 8'h01;
    cyc(1);
    irq_clr = 8'h00;
    chk("p0_clr_status", {24'd0, irq_status}, 32'h0);
    chk("p0_clr_irq_lag", {31'd0, irq}, 32'h1);
    cyc(1);
    chk("p0_clr_irq", {31'd0, irq}, 32'h0);

    // ---------------- pin3 glitch rejection ----------------
    irq_mode = 16'h00C1;
    pin_in   = 8'hAD;
    cyc(3);
    pin_in   = 8'hA5;
    cyc(8);
    chk("p3_glitch_data", {24'd0, data_in}, 32'hA5);
    chk("p3_glitch_status", {24'd0, irq_status}, 32'h0);

    // 4-cycle pulse is accepted, then the 4-cycle low is accepted too
    pin_in = 8'hAD;
    cyc(4);
    pin_in = 8'hA5;
    cyc(2);
    chk("p3_rise_data", {24'd0, data_in}, 32'hAD);
    chk("p3_rise_status", {24'd0, irq_status}, 32'h08);
    irq_clr = 8'h08;
    cyc(1);
    irq_clr = 8'h00;
    cyc(2);
    chk("p3_hold_data", {24'd0, data_in}, 32'hAD);
    chk("p3_hold_status", {24'd0, irq_status}, 32'h0);
    cyc(1);
    chk("p3_fall_data", {24'd0, data_in}, 32'hA5);
    chk("p3_fall_status", {24'd0, irq_status}, 32'h08);
    irq_clr = 8'h08;
    cyc(1);
    irq_clr = 8'h00;
    chk("p3_fall_clr", {24'd0, irq_status}, 32'h0);

    // ---------------- pin5 fall with simultaneous clear: set wins ----------------
    irq_mode = 16'h0CC1;
    pin_in   = 8'h85;
    cyc(5);
    irq_clr  = 8'h20;
    cyc(1);
    chk("p5_setwins_data", {24'd0, data_in}, 32'h85);
    chk("p5_setwins_status", {24'd0, irq_status}, 32'h20);
    chk("p5_masked_irq", {31'd0, irq}, 32'h0);
    irq_clr = 8'h00;
    irq_en  = 8'h21;
    cyc(1);
    chk("p5_en_irq", {31'd0, irq}, 32'h1);
    irq_clr = 8'h20;
    cyc(1);
    irq_clr = 8'h00;
    chk("p5_clr_status", {24'd0, irq_status}, 32'h0);
    cyc(1);
    chk("p5_clr_irq", {31'd0, irq}, 32'h0);

    // ---------------- output register and direction ----------------
    out_wr    = 1'b1;
    out_wdata = 8'h0F;
    cyc(1);
    out_wr    = 1'b0;
    chk("out_wr", {24'd0, pin_out}, 32'h0F);
    out_set = 8'h30;
    out_clr = 8'h11;
    cyc(1);
    out_set = 8'h00;
    out_clr = 8'h00;
    chk("out_set_clr", {24'd0, pin_out}, 32'h2E);
    out_tgl = 8'hFF;
    cyc(1);
    out_tgl = 8'h00;
    chk("out_tgl", {24'd0, pin_out}, 32'hD1);
    out_wr    = 1'b1;
    out_wdata = 8'hAA;
    out_clr   = 8'hFF;
    out_set   = 8'h0F;
    cyc(1);
    out_wr  = 1'b0;
    out_clr = 8'h00;
    out_set = 8'h00;
    chk("out_wr_prio", {24'd0, pin_out}, 32'hAA);
    dir_wr    = 1'b1;
    dir_wdata = 8'hF0;
    chk("dir_before", {24'd0, pin_oe}, 32'h0);
    cyc(1);
    dir_wr = 1'b0;
    chk("dir_after", {24'd0, pin_oe}, 32'hF0);

    // ---------------- reset mid-debounce with pending status ----------------
    irq_mode = 16'h00C0;
    irq_en   = 8'hFF;
    pin_in   = 8'h8D;
    cyc(6);
    chk("rm_status_set", {24'd0, irq_status}, 32'h08);
    cyc(1);
    chk("rm_irq_set", {31'd0, irq}, 32'h1);
    pin_in = 8'h85;
    cyc(3);
    rst = 1'b1;
    cyc(1);
    chk("rm_pin_out", {24'd0, pin_out}, 32'h0);
    chk("rm_pin_oe", {24'd0, pin_oe}, 32'h0);
    chk("rm_data_in", {24'd0, data_in}, 32'h0);
    chk("rm_status", {24'd0, irq_status}, 32'h0);
    chk("rm_irq", {31'd0, irq}, 32'h0);
    rst = 1'b0;
    cyc(10);
    chk("rm_post_data", {24'd0, data_in}, 32'h85);
    chk("rm_post_status", {24'd0, irq_status}, 32'h0);
    chk("rm_post_irq", {31'd0, irq}, 32'h0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
